// File: rtl/dma_req_arbiter_pkg.sv
// Shared types and constants for the DMA request arbiter.
// MAX_BURST must match the IO device buffer depth.
package dma_pkg;
    localparam int DMA_DATA_W    = 32;
    localparam int DMA_ADDR_W    = 9;
    localparam int DMA_MAX_BURST = 31;
    localparam int DMA_CNT_W     = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_XFER,
        ST_DONE
    } dma_state_t;
endpackage

// File: rtl/dma_req_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester above i_rr_ptr, with wrap.
module dma_rr_picker #(
    parameter int N_DEV = 2
) (
    input  logic [N_DEV-1:0] i_req,
    input  logic [2:0]       i_rr_ptr,
    output logic [2:0]       o_grant,
    output logic             o_valid
);

    // Offset i walks rr_ptr+1 upward; j matches it directly or after one wrap.
    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        for (int i = 0; i < N_DEV; i++) begin
            for (int j = 0; j < N_DEV; j++) begin
                if (!o_valid && i_req[j] &&
                    ((int'(i_rr_ptr) + 1 + i == j) || (int'(i_rr_ptr) + 1 + i == j + N_DEV))) begin
                    o_valid = 1'b1;
                    o_grant = 3'(j);
                end
            end
        end
    end

endmodule

// File: rtl/dma_req_arbiter.sv
// Round-robin DMA arbiter moving device buffer words into memory at per-channel addresses.
// Optional DMA_DONE_IRQ_EN adds done_irq/done_cnt completion reporting.
module dma_req_arbiter import dma_pkg::*; #(
    parameter int N_DEV     = 2,
    parameter int ADDR_W    = DMA_ADDR_W,
    parameter int DATA_W    = DMA_DATA_W,
    parameter int MAX_BURST = DMA_MAX_BURST
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_DEV-1:0]  dev_req,
    input  logic [DATA_W-1:0] dev_rdata,
    output logic [N_DEV-1:0]  dev_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic              mem_ready,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_chan,
    input  logic [ADDR_W-1:0] cfg_addr,
    output logic              cfg_err,
    output logic              busy,
    output logic [2:0]        grant_id
`ifdef DMA_DONE_IRQ_EN
    ,
    output logic              done_irq,
    output logic [4:0]        done_cnt
`endif
);

    dma_state_t           r_state;
    logic [2:0]           r_grant;
    logic [2:0]           r_rr_ptr;
    logic [DMA_CNT_W-1:0] r_word_cnt;
    logic [ADDR_W-1:0]    r_chan_addr [N_DEV];
    logic                 r_cfg_err;

    logic [2:0]           w_pick_grant;
    logic                 w_pick_valid;
    logic                 w_req_g;
    logic [ADDR_W-1:0]    w_base_g;
    logic                 w_wr;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_cfg_ok;

    dma_rr_picker #(.N_DEV(N_DEV)) u_pick (
        .i_req    (dev_req),
        .i_rr_ptr (r_rr_ptr),
        .o_grant  (w_pick_grant),
        .o_valid  (w_pick_valid)
    );

    always_comb begin
        w_req_g  = 1'b0;
        w_base_g = '0;
        for (int i = 0; i < N_DEV; i++) begin
            if (r_grant == 3'(i)) begin
                w_req_g  = dev_req[i];
                w_base_g = r_chan_addr[i];
            end
        end
    end

    // Write is held while mem_ready is low: address and popped data cannot move.
    assign w_wr      = (r_state == ST_XFER) && w_req_g;
    assign w_accept  = w_wr && mem_ready;
    assign w_last    = (r_word_cnt == DMA_CNT_W'(MAX_BURST - 1));
    assign mem_we    = w_wr;
    assign mem_addr  = w_wr ? w_base_g + ADDR_W'(r_word_cnt) : '0;
    assign mem_wdata = w_wr ? dev_rdata : '0;

    always_comb begin
        dev_ack = '0;
        for (int i = 0; i < N_DEV; i++)
            dev_ack[i] = w_accept && (r_grant == 3'(i));
    end

    // Base of the channel in flight is locked until the grant retires.
    assign w_cfg_ok = cfg_we && ({1'b0, cfg_chan} < 4'(N_DEV)) &&
                      !((cfg_chan == r_grant) && (r_state != ST_IDLE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_rr_ptr   <= 3'(N_DEV - 1);
            r_word_cnt <= '0;
            r_cfg_err  <= 1'b0;
            for (int i = 0; i < N_DEV; i++) r_chan_addr[i] <= '0;
        end else begin
            r_cfg_err <= cfg_we && !w_cfg_ok;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_grant    <= w_pick_grant;
                        r_word_cnt <= '0;
                        r_state    <= ST_GRANT;
                    end
                end
                ST_GRANT: r_state <= ST_XFER;
                ST_XFER: begin
                    if (!w_req_g) begin
                        r_state <= ST_DONE;
                    end else if (mem_ready) begin
                        r_word_cnt <= r_word_cnt + 1'b1;
                        if (w_last) r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_rr_ptr <= r_grant;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
            for (int i = 0; i < N_DEV; i++) begin
                if ((r_state == ST_DONE) && (r_grant == 3'(i)))
                    r_chan_addr[i] <= r_chan_addr[i] + ADDR_W'(r_word_cnt);
                if (w_cfg_ok && (cfg_chan == 3'(i)))
                    r_chan_addr[i] <= cfg_addr;
            end
        end
    end

    assign cfg_err  = r_cfg_err;
    assign busy     = (r_state != ST_IDLE);
    assign grant_id = r_grant;

`ifdef DMA_DONE_IRQ_EN
    logic [4:0] r_done_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  r_done_cnt <= '0;
        else if (r_state == ST_DONE) r_done_cnt <= 5'(r_word_cnt);
    end

    assign done_irq = (r_state == ST_DONE) && (r_word_cnt != '0);
    assign done_cnt = r_done_cnt;
`endif

endmodule

// File: tb/tb_dma_req_arbiter.sv
// Directed bench for dma_req_arbiter: device FIFO model, write monitor, per-scenario tasks.
module tb_dma_req_arbiter;
    localparam int N_DEV = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  dev_req;
    logic [31:0] dev_rdata;
    logic [1:0]  dev_ack;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_ready = 1'b1;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_chan = '0;
    logic [8:0]  cfg_addr = '0;
    logic        cfg_err;
    logic        busy;
    logic [2:0]  grant_id;
`ifdef DMA_DONE_IRQ_EN
    logic        done_irq;
    logic [4:0]  done_cnt;
`endif

    dma_req_arbiter #(.N_DEV(N_DEV)) dut (
        .clk(clk), .rst_n(rst_n), .dev_req(dev_req), .dev_rdata(dev_rdata),
        .dev_ack(dev_ack), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_ready(mem_ready), .cfg_we(cfg_we), .cfg_chan(cfg_chan), .cfg_addr(cfg_addr),
        .cfg_err(cfg_err), .busy(busy), .grant_id(grant_id)
`ifdef DMA_DONE_IRQ_EN
        , .done_irq(done_irq), .done_cnt(done_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dat(input int g, input int k);
        return 32'hD000_0000 + 32'(g << 16) + 32'(k);
    endfunction

    // Device model: pushed words are queued, each dev_ack pops one.
    int pushed [N_DEV] = '{default: 0};
    int popped [N_DEV] = '{default: 0};
    int wcnt   [N_DEV] = '{default: 0};
    int n_tests = 0, n_fail = 0, seq_err = 0, strobe_viol = 0;
    logic prev_busy = 1'b0;
    logic [8:0]  wa [$];
    logic [31:0] wd [$];
    logic [2:0]  wg [$];

    always_comb begin
        dev_req = '0;
        for (int i = 0; i < N_DEV; i++) dev_req[i] = (pushed[i] != popped[i]);
    end
    always_comb dev_rdata = dat(int'(grant_id[0]), popped[grant_id[0]]);

    always @(posedge clk)
        for (int i = 0; i < N_DEV; i++)
            if (dev_ack[i]) popped[i] <= popped[i] + 1;

    always @(negedge clk) begin
        if (rst_n && mem_we && mem_ready) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
            wg.push_back(grant_id);
            if (mem_wdata !== dat(int'(grant_id[0]), wcnt[grant_id[0]])) seq_err <= seq_err + 1;
            wcnt[grant_id[0]] <= wcnt[grant_id[0]] + 1;
        end
        if (busy && !prev_busy && (mem_we || dev_ack != 2'b00)) strobe_viol <= strobe_viol + 1;
        if (dev_ack != 2'b00 && (!(mem_we && mem_ready) || dev_ack != (2'b01 << grant_id[0])))
            strobe_viol <= strobe_viol + 1;
        prev_busy <= busy;
    end

    task automatic push(input int d, input int n);
        @(posedge clk); #2;
        pushed[d] = pushed[d] + n;
    endtask

    task automatic cfg_write(input logic [2:0] c, input logic [8:0] a);
        @(posedge clk); #2;
        cfg_we = 1'b1; cfg_chan = c; cfg_addr = a;
        @(posedge clk); #2;
        cfg_we = 1'b0;
    endtask

    task automatic wait_quiet(output bit ok);
        ok = 1'b0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 2000; c++) begin
            if (!busy && dev_req == 2'b00) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_tests++;
        if ({mem_we, dev_ack, busy, cfg_err, grant_id} !== 8'h00) begin
            n_fail++; $display("FAIL reset_ctrl got=%h exp=00", {mem_we, dev_ack, busy, cfg_err, grant_id});
        end
        n_tests++;
        if (mem_addr !== 9'h000) begin n_fail++; $display("FAIL reset_addr got=%h exp=000", mem_addr); end
        n_tests++;
        if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata); end
        @(posedge clk); #2 rst_n = 1'b1;
    endtask

    task automatic test_basic;
        bit ok; int b;
        cfg_write(3'd0, 9'h010);
        @(negedge clk);
        n_tests++;
        if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL basic_cfg_err got=%b exp=0", cfg_err); end
        b = wa.size();
        push(0, 3);
        wait_quiet(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL basic_timeout got=busy exp=idle"); end
        n_tests++;
        if (wa.size() - b != 3) begin n_fail++; $display("FAIL basic_count got=%0d exp=3", wa.size() - b); end
        for (int j = 0; j < 3 && b + j < wa.size(); j++) begin
            n_tests++;
            if (wa[b+j] !== 9'(9'h010 + j) || wd[b+j] !== dat(0, j)) begin
                n_fail++; $display("FAIL basic_wr%0d got=%h/%h exp=%h/%h", j, wa[b+j], wd[b+j], 9'(9'h010 + j), dat(0, j));
            end
        end
        n_tests++;
        if (popped[0] != 3) begin n_fail++; $display("FAIL basic_acks got=%0d exp=3", popped[0]); end
        push(0, 1);
        wait_quiet(ok);
        n_tests++;
        if (wa.size() != b + 4 || wa[b+3] !== 9'h013) begin
            n_fail++; $display("FAIL basic_next_base got=%h exp=013", wa[wa.size()-1]);
        end
    endtask

    task automatic test_wrap;
        bit ok; int b;
        logic [8:0] ea [5] = '{9'h1FE, 9'h1FF, 9'h000, 9'h001, 9'h002};
        cfg_write(3'd1, 9'h1FE);
        b = wa.size();
        push(1, 4);
        wait_quiet(ok);
        push(1, 1);
        wait_quiet(ok);
        n_tests++;
        if (!ok || wa.size() - b != 5) begin n_fail++; $display("FAIL wrap_count got=%0d exp=5", wa.size() - b); end
        for (int j = 0; j < 5 && b + j < wa.size(); j++) begin
            n_tests++;
            if (wa[b+j] !== ea[j] || wg[b+j] !== 3'd1) begin
                n_fail++; $display("FAIL wrap_addr%0d got=%h/g%0d exp=%h/g1", j, wa[b+j], wg[b+j], ea[j]);
            end
        end
    endtask

    task automatic test_back_to_back;
        bit ok; int b, errs;
        logic [8:0] exp_a;
        b = wa.size();
        @(posedge clk); #2;
        pushed[0] = pushed[0] + 62;
        pushed[1] = pushed[1] + 62;
        wait_quiet(ok);
        n_tests++;
        if (!ok || wa.size() - b != 124) begin n_fail++; $display("FAIL rr_count got=%0d exp=124", wa.size() - b); end
        errs = 0;
        for (int j = 0; j < 124 && b + j < wa.size(); j++) begin
            exp_a = 9'(((j / 31) % 2 == 0 ? 9'h014 : 9'h003) + (j / 62) * 31 + (j % 31));
            if (wa[b+j] !== exp_a || wg[b+j] !== 3'((j / 31) % 2)) errs++;
        end
        n_tests++;
        if (errs != 0) begin n_fail++; $display("FAIL rr_stream got=%0d bad exp=0 bad", errs); end
        n_tests++;
        if (wa.size() >= b + 32 && (wd[b] !== dat(0, 4) || wd[b+31] !== dat(1, 5))) begin
            n_fail++; $display("FAIL rr_data got=%h/%h exp=%h/%h", wd[b], wd[b+31], dat(0, 4), dat(1, 5));
        end
        n_tests++;
        if (strobe_viol != 0) begin n_fail++; $display("FAIL rr_strobes got=%0d exp=0", strobe_viol); end
    endtask

    task automatic test_stall;
        bit ok; int b;
        b = wa.size();
        push(0, 6);
        for (int c = 0; c < 50 && wa.size() - b < 2; c++) begin @(negedge clk); #1; end
        @(posedge clk); #2 mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_tests++;
            if (mem_we !== 1'b1 || mem_addr !== 9'h054 || mem_wdata !== dat(0, 68) || dev_ack !== 2'b00) begin
                n_fail++; $display("FAIL stall_hold%0d got=%b/%h/%h/%b exp=1/054/%h/00", k, mem_we, mem_addr, mem_wdata, dev_ack, dat(0, 68));
            end
        end
        @(posedge clk); #2 mem_ready = 1'b1;
        wait_quiet(ok);
        n_tests++;
        if (!ok || wa.size() - b != 6) begin n_fail++; $display("FAIL stall_count got=%0d exp=6", wa.size() - b); end
        for (int j = 0; j < 6 && b + j < wa.size(); j++) begin
            n_tests++;
            if (wa[b+j] !== 9'(9'h052 + j) || wd[b+j] !== dat(0, 66 + j)) begin
                n_fail++; $display("FAIL stall_wr%0d got=%h/%h exp=%h/%h", j, wa[b+j], wd[b+j], 9'(9'h052 + j), dat(0, 66 + j));
            end
        end
    endtask

    task automatic test_cfg_err;
        bit ok, seen; int b;
        b = wa.size();
        mem_ready = 1'b0;
        push(1, 5);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin @(negedge clk); seen = mem_we; end
        n_tests++;
        if (!seen || mem_addr !== 9'h041) begin n_fail++; $display("FAIL cfg_park got=%b/%h exp=1/041", seen, mem_addr); end
        @(posedge clk); #2 cfg_we = 1'b1; cfg_chan = 3'd1; cfg_addr = 9'h100;
        @(posedge clk); #2 cfg_chan = 3'd0; cfg_addr = 9'h080;
        @(negedge clk);
        n_tests++;
        if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfg_err_active got=%b exp=1", cfg_err); end
        @(posedge clk); #2 cfg_chan = 3'd5; cfg_addr = 9'h0AA;
        @(negedge clk);
        n_tests++;
        if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_err_idle_chan got=%b exp=0", cfg_err); end
        @(posedge clk); #2 cfg_we = 1'b0;
        @(negedge clk);
        n_tests++;
        if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfg_err_range got=%b exp=1", cfg_err); end
        @(negedge clk);
        n_tests++;
        if (cfg_err !== 1'b0 || mem_addr !== 9'h041) begin
            n_fail++; $display("FAIL cfg_err_pulse got=%b/%h exp=0/041", cfg_err, mem_addr);
        end
        @(posedge clk); #2 mem_ready = 1'b1;
        wait_quiet(ok);
        push(0, 1);
        wait_quiet(ok);
        n_tests++;
        if (!ok || wa.size() - b != 6) begin n_fail++; $display("FAIL cfg_count got=%0d exp=6", wa.size() - b); end
        for (int j = 0; j < 5 && b + j < wa.size(); j++) begin
            n_tests++;
            if (wa[b+j] !== 9'(9'h041 + j)) begin n_fail++; $display("FAIL cfg_keep%0d got=%h exp=%h", j, wa[b+j], 9'(9'h041 + j)); end
        end
        n_tests++;
        if (wa.size() == b + 6 && wa[b+5] !== 9'h080) begin n_fail++; $display("FAIL cfg_apply got=%h exp=080", wa[b+5]); end
    endtask

    task automatic test_reset_mid;
        bit ok; int b, b2;
        b = wa.size();
        @(posedge clk); #2;
        pushed[0] = pushed[0] + 10;
        pushed[1] = pushed[1] + 10;
        for (int c = 0; c < 50 && wa.size() - b < 3; c++) begin @(negedge clk); #1; end
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({mem_we, dev_ack, busy, grant_id} !== 7'h00 || mem_addr !== 9'h000 || mem_wdata !== 32'h0) begin
            n_fail++; $display("FAIL rstmid_async got=%b/%b/%b/%0d/%h exp=0/00/0/0/000", mem_we, dev_ack, busy, grant_id, mem_addr);
        end
        b2 = wa.size();
        n_tests++;
        if (b2 - b != 3 || wg[b] !== 3'd1) begin n_fail++; $display("FAIL rstmid_pre got=%0d/g%0d exp=3/g1", b2 - b, wg[b]); end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_quiet(ok);
        n_tests++;
        if (!ok || wa.size() - b2 != 17) begin n_fail++; $display("FAIL rstmid_count got=%0d exp=17", wa.size() - b2); end
        if (wa.size() == b2 + 17) begin
            n_tests++;
            if (wg[b2] !== 3'd0 || wa[b2] !== 9'h000 || wd[b2] !== dat(0, 73)) begin
                n_fail++; $display("FAIL rstmid_first got=g%0d/%h/%h exp=g0/000/%h", wg[b2], wa[b2], wd[b2], dat(0, 73));
            end
            n_tests++;
            if (wg[b2+10] !== 3'd1 || wa[b2+10] !== 9'h000 || wd[b2+10] !== dat(1, 75)) begin
                n_fail++; $display("FAIL rstmid_dev1 got=g%0d/%h/%h exp=g1/000/%h", wg[b2+10], wa[b2+10], wd[b2+10], dat(1, 75));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_back_to_back();
        test_stall();
        test_cfg_err();
        test_reset_mid();
        n_tests++;
        if (seq_err != 0) begin n_fail++; $display("FAIL data_sequence got=%0d bad exp=0 bad", seq_err); end
        n_tests++;
        if (strobe_viol != 0) begin n_fail++; $display("FAIL strobe_rules got=%0d bad exp=0 bad", strobe_viol); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
